// File: rtl/switch_output_arbiter.sv
// rtl/switch_output_arbiter.sv - round-robin packet arbiter with grant lock and stall watchdog
module switch_output_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int STALL_MAX = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_last,
    output logic [$clog2(NUM_REQ)-1:0]   out_src,
    input  logic                         out_ready,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy,
    output logic                         stall_abort
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(STALL_MAX + 1);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_XFER = 1'b1;

    logic               state_q, state_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SRC_W-1:0]   out_src_q, out_src_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               stall_abort_q, stall_abort_d;

    logic               pick_found;
    logic [SRC_W-1:0]   pick_idx;
    logic               beat_accept;
    logic [SRC_W-1:0]   next_ptr;

    // Pass-through of the granted source; everything is zero while idle
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        req_ready = '0;
        if (state_q == ST_XFER) begin
            out_valid            = req_valid[out_src_q];
            out_data             = req_data[out_src_q*DATA_W +: DATA_W];
            out_last             = req_last[out_src_q];
            req_ready[out_src_q] = out_ready;
        end
    end

    // Round-robin pick: first valid source at or after rr_ptr, wrapping
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = SRC_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign beat_accept = out_valid & out_ready;
    assign next_ptr    = (out_src_q == SRC_W'(NUM_REQ - 1)) ? '0 : out_src_q + 1'b1;

    // Next-state: arbitrate in IDLE, hold the lock until last beat or watchdog release
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        out_src_d     = out_src_q;
        stall_cnt_d   = stall_cnt_q;
        stall_abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d     = ST_XFER;
                    out_src_d   = pick_idx;
                    grant_d     = NUM_REQ'(1) << pick_idx;
                    stall_cnt_d = '0;
                end
            end
            ST_XFER: begin
                if (beat_accept && out_last) begin
                    state_d     = ST_IDLE;
                    grant_d     = '0;
                    rr_ptr_d    = next_ptr;
                    stall_cnt_d = '0;
                end else if (!req_valid[out_src_q]) begin
                    if (stall_cnt_q == CNT_W'(STALL_MAX - 1)) begin
                        state_d       = ST_IDLE;
                        grant_d       = '0;
                        rr_ptr_d      = next_ptr;
                        stall_cnt_d   = '0;
                        stall_abort_d = 1'b1;
                    end else if (stall_cnt_q < CNT_W'(STALL_MAX - 1)) begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end else begin
                    stall_cnt_d = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                grant_d     = '0;
                stall_cnt_d = '0;
            end
        endcase
    end

    // State registers; reset drops any packet in flight without an abort pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            out_src_q     <= '0;
            stall_cnt_q   <= '0;
            stall_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            out_src_q     <= out_src_d;
            stall_cnt_q   <= stall_cnt_d;
            stall_abort_q <= stall_abort_d;
        end
    end

    assign grant       = grant_q;
    assign out_src     = out_src_q;
    assign busy        = (state_q == ST_XFER);
    assign stall_abort = stall_abort_q;

endmodule

// File: tb/tb_switch_output_arbiter.sv
// tb/tb_switch_output_arbiter.sv - self-checking bench for switch_output_arbiter
module tb_switch_output_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_src;
    logic        out_ready;
    logic [3:0]  grant;
    logic        busy;
    logic        stall_abort;

    int checks = 0;
    int errors = 0;

    switch_output_arbiter #(.NUM_REQ(4), .DATA_W(8), .STALL_MAX(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_src     (out_src),
        .out_ready   (out_ready),
        .grant       (grant),
        .busy        (busy),
        .stall_abort (stall_abort)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        rdy;
        logic [3:0]  e_grant;
        logic        e_valid;
        logic [7:0]  e_data;
        logic        e_last;
        logic [3:0]  e_ready;
        logic        e_busy;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Reference model state: owner (-1 idle), next priority, quiet-cycle run length
    int m_owner, m_next, m_quiet, pct, found, n;
    bit m_abort, new_abort;
    logic [3:0] e_grant, e_ready;
    logic       e_valid, e_last;
    logic [7:0] e_data;

    initial begin
        tbl[0] = '{4'b0100, 4'b0000, 32'h00A1_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0};
        tbl[1] = '{4'b0100, 4'b0000, 32'h00A1_0000, 1'b1, 4'b0100, 1'b1, 8'hA1, 1'b0, 4'b0100, 1'b1};
        tbl[2] = '{4'b0100, 4'b0000, 32'h00A2_0000, 1'b1, 4'b0100, 1'b1, 8'hA2, 1'b0, 4'b0100, 1'b1};
        tbl[3] = '{4'b0100, 4'b0100, 32'h00A3_0000, 1'b1, 4'b0100, 1'b1, 8'hA3, 1'b1, 4'b0100, 1'b1};
        tbl[4] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0};
        tbl[5] = '{4'b1111, 4'b1111, 32'hD3D2_D1D0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0};
        tbl[6] = '{4'b1111, 4'b1111, 32'hD3D2_D1D0, 1'b1, 4'b1000, 1'b1, 8'hD3, 1'b1, 4'b1000, 1'b1};
        tbl[7] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0};

        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
        do_reset();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_src", 32'(out_src), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_abort", 32'(stall_abort), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ready", 32'(req_ready), 0);

        // Single source from src 2, then rr_ptr=3 shown by src 3 winning a full contest
        for (int i = 0; i < 8; i++) begin
            req_valid = tbl[i].valid; req_last = tbl[i].last;
            req_data = tbl[i].data; out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].e_grant));
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_last", i), 32'(out_last), 32'(tbl[i].e_last));
            chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            step();
        end

        // Round-robin with everyone requesting single-beat packets
        do_reset();
        req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'h4433_2211; out_ready = 1'b1;
        for (int p = 0; p < 8; p++) begin
            #1;
            chk($sformatf("rr%0d_bubble", p), 32'(grant), 0);
            step();
            chk($sformatf("rr%0d_src", p), 32'(out_src), 32'(p % 4));
            chk($sformatf("rr%0d_grant", p), 32'(grant), 32'(4'b0001 << (p % 4)));
            chk($sformatf("rr%0d_ready", p), 32'(req_ready), 32'(4'b0001 << (p % 4)));
            step();
        end

        // Lock under contention: src 0 raises valid during src 1's beat 2
        do_reset();
        req_valid = 4'b0010; req_last = '0; req_data = 32'h0000_1100; out_ready = 1'b1;
        step();
        for (int b = 1; b <= 4; b++) begin
            req_data  = {16'h0, 8'(8'h10 + b), 8'h50};
            req_last  = (b == 4) ? 4'b0010 : 4'b0000;
            if (b >= 2) req_valid = 4'b0011;
            #1;
            chk($sformatf("lock_b%0d_data", b), 32'(out_data), 32'(8'h10 + b));
            chk($sformatf("lock_b%0d_ready", b), 32'(req_ready), 32'h2);
            step();
        end
        req_valid = 4'b0001; req_last = 4'b0001;
        #1;
        chk("lock_bubble", 32'(grant), 0);
        step();
        chk("lock_src0", 32'(grant), 32'h1);
        chk("lock_src0_data", 32'(out_data), 32'h50);

        // Backpressure: src 3 held 40 cycles with out_ready low
        do_reset();
        req_valid = 4'b1000; req_last = '0; req_data = 32'h3C00_0000; out_ready = 1'b0;
        step();
        for (int c = 0; c < 40; c++) begin
            #1;
            if (c % 8 == 0 || c == 39) begin
                chk($sformatf("bp%0d_ready", c), 32'(req_ready), 0);
                chk($sformatf("bp%0d_data", c), 32'(out_data), 32'h3C);
            end
            chk($sformatf("bp%0d_abort", c), 32'(stall_abort), 0);
            step();
        end
        chk("bp_grant", 32'(grant), 32'h8);
        out_ready = 1'b1; req_last = 4'b1000;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'h8);
        step();
        chk("bp_done_grant", 32'(grant), 0);

        // Watchdog: src 0 sends one beat then goes quiet
        do_reset();
        req_valid = 4'b0001; req_last = '0; req_data = 32'h0000_00E1; out_ready = 1'b1;
        step();
        step();
        req_valid = '0;
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (stall_abort && n == 0) n = c;
            if (n != 0) break;
        end
        chk("wd_latency", 32'(n), 16);
        chk("wd_grant", 32'(grant), 0);
        chk("wd_busy", 32'(busy), 0);
        req_valid = 4'b1111; req_last = 4'b1111;
        step();
        chk("wd_pulse_len", 32'(stall_abort), 0);
        chk("wd_next_src1", 32'(grant), 32'h2);

        // Reset mid-packet forgets the packet and rr_ptr
        do_reset();
        req_valid = 4'b0010; req_last = 4'b0010; req_data = 32'h0000_0000;
        step();
        chk("rm_src1", 32'(grant), 32'h2);
        step();
        req_valid = 4'b0100; req_last = '0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; req_valid = 4'b1111; req_last = 4'b1111;
        #1;
        chk("rm_grant", 32'(grant), 0);
        chk("rm_valid", 32'(out_valid), 0);
        chk("rm_ready", 32'(req_ready), 0);
        chk("rm_abort", 32'(stall_abort), 0);
        step();
        chk("rm_first_src0", 32'(grant), 32'h1);

        // Randomized traffic against the reference model
        do_reset();
        m_owner = -1; m_next = 0; m_quiet = 0; m_abort = 0;
        for (int c = 0; c < 3000; c++) begin
            pct = ((c / 150) % 3 == 0) ? 90 : (((c / 150) % 3 == 1) ? 50 : 8);
            for (int i = 0; i < 4; i++) begin
                req_valid[i] = ($urandom_range(99) < pct);
                req_last[i]  = ($urandom_range(99) < 30);
            end
            req_data  = $urandom;
            out_ready = ($urandom_range(99) < 70);
            #1;
            e_grant = '0; e_ready = '0; e_valid = 0; e_last = 0; e_data = '0;
            if (m_owner >= 0) begin
                e_grant          = 4'b0001 << m_owner;
                e_valid          = req_valid[m_owner];
                e_last           = req_last[m_owner];
                e_data           = req_data[m_owner*8 +: 8];
                e_ready[m_owner] = out_ready;
            end
            chk("rnd_grant", 32'(grant), 32'(e_grant));
            chk("rnd_valid", 32'(out_valid), 32'(e_valid));
            chk("rnd_data", 32'(out_data), 32'(e_data));
            chk("rnd_last", 32'(out_last), 32'(e_last));
            chk("rnd_ready", 32'(req_ready), 32'(e_ready));
            chk("rnd_busy", 32'(busy), 32'(m_owner >= 0));
            chk("rnd_abort", 32'(stall_abort), 32'(m_abort));
            if (m_owner >= 0) chk("rnd_src", 32'(out_src), 32'(m_owner));

            new_abort = 0;
            if (m_owner < 0) begin
                found = 0;
                for (int k = 0; k < 4; k++) begin
                    if (found == 0 && req_valid[(m_next + k) % 4]) begin
                        m_owner = (m_next + k) % 4;
                        found   = 1;
                    end
                end
                m_quiet = 0;
            end else if (req_valid[m_owner] && out_ready && req_last[m_owner]) begin
                m_next  = (m_owner + 1) % 4;
                m_owner = -1;
            end else if (!req_valid[m_owner]) begin
                m_quiet++;
                if (m_quiet == 16) begin
                    new_abort = 1;
                    m_next    = (m_owner + 1) % 4;
                    m_owner   = -1;
                end
            end else begin
                m_quiet = 0;
            end
            m_abort = new_abort;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
